// File: rtl/ariane_pkg.sv
// rtl/ariane_pkg.sv - shared types for the shared functional-unit arbiter
package ariane_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      DRAIN = 2'd2
   } shared_fu_state_e;

endpackage

// File: rtl/shared_fu_rr_sel.sv
// rtl/shared_fu_rr_sel.sv - one-hot winner selection; SHARED_FU_RR_ARB_EN selects round-robin, else fixed priority
module shared_fu_rr_sel #(
   parameter int unsigned NR_REQ = 2,
   parameter int unsigned IDX_W  = (NR_REQ > 1) ? $clog2(NR_REQ) : 1
) (
   input  logic [NR_REQ-1:0] valid_i,
`ifdef SHARED_FU_RR_ARB_EN
   input  logic [IDX_W-1:0]  ptr_i,
`endif
   output logic [NR_REQ-1:0] gnt_o,
   output logic [IDX_W-1:0]  idx_o,
   output logic              any_o
);

   logic             lo_found;
   logic [IDX_W-1:0] lo_idx;
`ifdef SHARED_FU_RR_ARB_EN
   logic             hi_found;
   logic [IDX_W-1:0] hi_idx;
`endif

   // Descending scan: the last hit is the lowest index; hi_* restricts to ports at/after the pointer.
   always_comb begin
      lo_found = 1'b0;
      lo_idx   = '0;
`ifdef SHARED_FU_RR_ARB_EN
      hi_found = 1'b0;
      hi_idx   = '0;
`endif
      for (int i = NR_REQ - 1; i >= 0; i--) begin
         if (valid_i[i]) begin
            lo_found = 1'b1;
            lo_idx   = IDX_W'(i);
`ifdef SHARED_FU_RR_ARB_EN
            if (IDX_W'(i) >= ptr_i) begin
               hi_found = 1'b1;
               hi_idx   = IDX_W'(i);
            end
`endif
         end
      end
   end

`ifdef SHARED_FU_RR_ARB_EN
   assign idx_o = hi_found ? hi_idx : lo_idx;
`else
   assign idx_o = lo_idx;
`endif
   assign any_o = lo_found;

   always_comb begin
      gnt_o = '0;
      if (any_o) gnt_o[idx_o] = 1'b1;
   end

endmodule

// File: rtl/shared_fu_arbiter.sv
// rtl/shared_fu_arbiter.sv - arbitrates issue ports onto one shared unit, single op in flight
// Build option SHARED_FU_RR_ARB_EN: round-robin arbitration instead of fixed priority.
module shared_fu_arbiter
   import ariane_pkg::*;
#(
   parameter int unsigned NR_REQ        = 2,
   parameter int unsigned TRANS_ID_BITS = 3,
   parameter int unsigned DATA_W        = 64
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic                                  flush_i,
   input  logic [NR_REQ-1:0]                     req_valid_i,
   output logic [NR_REQ-1:0]                     req_ready_o,
   input  logic [NR_REQ-1:0][TRANS_ID_BITS-1:0]  req_trans_id_i,
   input  logic [NR_REQ-1:0][DATA_W-1:0]         req_data_i,
   output logic                                  fu_valid_o,
   input  logic                                  fu_ready_i,
   output logic [DATA_W-1:0]                     fu_data_o,
   input  logic                                  fu_done_i,
   input  logic [DATA_W-1:0]                     fu_result_i,
   output logic                                  wb_valid_o,
   output logic [TRANS_ID_BITS-1:0]              wb_trans_id_o,
   output logic [DATA_W-1:0]                     wb_data_o,
   output logic                                  busy_o
);

   localparam int unsigned IDX_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

   shared_fu_state_e          state_q;
   logic [TRANS_ID_BITS-1:0]  tid_q;
   logic                      wb_valid_q;
   logic [TRANS_ID_BITS-1:0]  wb_tid_q;
   logic [DATA_W-1:0]         wb_data_q;

   logic                      allow;
   logic                      any_valid;
   logic                      hs;
   logic [NR_REQ-1:0]         sel_gnt;
   logic [IDX_W-1:0]          sel_idx;

`ifdef SHARED_FU_RR_ARB_EN
   logic [IDX_W-1:0]          ptr_q;
   logic [IDX_W-1:0]          ptr_d;

   assign ptr_d = (sel_idx == IDX_W'(NR_REQ - 1)) ? '0 : sel_idx + 1'b1;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)   ptr_q <= '0;
      else if (hs) ptr_q <= ptr_d;
   end
`endif

   shared_fu_rr_sel #(
      .NR_REQ (NR_REQ),
      .IDX_W  (IDX_W)
   ) u_sel (
      .valid_i (req_valid_i),
`ifdef SHARED_FU_RR_ARB_EN
      .ptr_i   (ptr_q),
`endif
      .gnt_o   (sel_gnt),
      .idx_o   (sel_idx),
      .any_o   (any_valid)
   );

   // Grant path is combinational so the operand reaches the unit in the handshake cycle.
   assign allow       = !rst_i && (state_q == IDLE) && fu_ready_i && !flush_i;
   assign req_ready_o = allow ? sel_gnt : '0;
   assign hs          = allow && any_valid;
   assign fu_valid_o  = hs;
   assign fu_data_o   = hs ? req_data_i[sel_idx] : '0;

   assign busy_o        = (state_q != IDLE);
   assign wb_valid_o    = wb_valid_q;
   assign wb_trans_id_o = wb_tid_q;
   assign wb_data_o     = wb_data_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         tid_q      <= '0;
         wb_valid_q <= 1'b0;
         wb_tid_q   <= '0;
         wb_data_q  <= '0;
      end else begin
         wb_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (hs) begin
                  state_q <= BUSY;
                  tid_q   <= req_trans_id_i[sel_idx];
               end
            end
            BUSY: begin
               // A flush coinciding with completion drops the result outright.
               if (fu_done_i) begin
                  state_q <= IDLE;
                  if (!flush_i) begin
                     wb_valid_q <= 1'b1;
                     wb_tid_q   <= tid_q;
                     wb_data_q  <= fu_result_i;
                  end
               end else if (flush_i) begin
                  state_q <= DRAIN;
               end
            end
            DRAIN: begin
               if (fu_done_i) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_shared_fu_arbiter.sv
// tb/tb_shared_fu_arbiter.sv - directed self-checking bench for shared_fu_arbiter
module tb_shared_fu_arbiter;

   logic             clk;
   logic             rst;
   logic             flush;
   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [1:0][2:0]  req_tid;
   logic [1:0][63:0] req_data;
   logic             fu_valid;
   logic             fu_ready;
   logic [63:0]      fu_data;
   logic             fu_done;
   logic [63:0]      fu_result;
   logic             wb_valid;
   logic [2:0]       wb_tid;
   logic [63:0]      wb_data;
   logic             busy;

   int checks = 0;
   int errors = 0;

   shared_fu_arbiter #(
      .NR_REQ        (2),
      .TRANS_ID_BITS (3),
      .DATA_W        (64)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .flush_i        (flush),
      .req_valid_i    (req_valid),
      .req_ready_o    (req_ready),
      .req_trans_id_i (req_tid),
      .req_data_i     (req_data),
      .fu_valid_o     (fu_valid),
      .fu_ready_i     (fu_ready),
      .fu_data_o      (fu_data),
      .fu_done_i      (fu_done),
      .fu_result_i    (fu_result),
      .wb_valid_o     (wb_valid),
      .wb_trans_id_o  (wb_tid),
      .wb_data_o      (wb_data),
      .busy_o         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      logic [1:0] exp_port;

      rst       = 1'b1;
      flush     = 1'b0;
      req_valid = 2'b01;
      req_tid   = '0;
      req_data  = '0;
      req_data[0] = 64'hDEAD;
      fu_ready  = 1'b1;
      fu_done   = 1'b0;
      fu_result = '0;
      #2;
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_fu_valid", 64'(fu_valid), 64'd0);
      chk("rst_fu_data", fu_data, 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_wb_valid", 64'(wb_valid), 64'd0);
      chk("rst_wb_tid", 64'(wb_tid), 64'd0);
      chk("rst_wb_data", wb_data, 64'd0);
      req_valid = 2'b00;
      tick();
      rst = 1'b0;
      tick();

      // Basic operation: grant port 0, done three cycles later
      req_valid   = 2'b01;
      req_tid[0]  = 3'd5;
      req_data[0] = 64'h11;
      #1;
      chk("t1_req_ready", 64'(req_ready), 64'b01);
      chk("t1_fu_valid", 64'(fu_valid), 64'd1);
      chk("t1_fu_data", fu_data, 64'h11);
      tick();
      req_valid   = 2'b10;
      req_data[1] = 64'h99;
      #1;
      chk("t1_busy", 64'(busy), 64'd1);
      chk("t1_busy_no_ready", 64'(req_ready), 64'd0);
      chk("t1_busy_no_fu_valid", 64'(fu_valid), 64'd0);
      chk("t1_busy_fu_data_zero", fu_data, 64'd0);
      req_valid = 2'b00;
      tick();
      tick();
      fu_done   = 1'b1;
      fu_result = 64'h22;
      #1;
      chk("t1_wb_not_early", 64'(wb_valid), 64'd0);
      tick();
      fu_done = 1'b0;
      chk("t1_wb_valid", 64'(wb_valid), 64'd1);
      chk("t1_wb_tid", 64'(wb_tid), 64'd5);
      chk("t1_wb_data", wb_data, 64'h22);
      chk("t1_idle", 64'(busy), 64'd0);
      tick();
      chk("t1_wb_single", 64'(wb_valid), 64'd0);

      // Fresh pointer, then both ports valid continuously
      rst = 1'b1;
      #2;
      rst = 1'b0;
      tick();
      req_valid   = 2'b11;
      req_tid[0]  = 3'd1;
      req_tid[1]  = 3'd2;
      req_data[0] = 64'hA0;
      req_data[1] = 64'hB1;
      for (int g = 0; g < 4; g++) begin
`ifdef SHARED_FU_RR_ARB_EN
         exp_port = 2'(g % 2);
`else
         exp_port = 2'd0;
`endif
         #1;
         chk($sformatf("t2_ready_g%0d", g), 64'(req_ready), (exp_port == 2'd0) ? 64'b01 : 64'b10);
         chk($sformatf("t2_fu_data_g%0d", g), fu_data, (exp_port == 2'd0) ? 64'hA0 : 64'hB1);
         tick();
         fu_done   = 1'b1;
         fu_result = 64'h100 + 64'(g);
         tick();
         fu_done = 1'b0;
         if (g == 3) req_valid = 2'b00;
         chk($sformatf("t2_wb_valid_g%0d", g), 64'(wb_valid), 64'd1);
         chk($sformatf("t2_wb_tid_g%0d", g), 64'(wb_tid), (exp_port == 2'd0) ? 64'd1 : 64'd2);
         chk($sformatf("t2_wb_data_g%0d", g), wb_data, 64'h100 + 64'(g));
      end
      tick();

      // Flush one cycle after grant, done two cycles later
      req_valid   = 2'b01;
      req_tid[0]  = 3'd3;
      req_data[0] = 64'h33;
      #1;
      chk("t3_grant", 64'(req_ready), 64'b01);
      tick();
      req_valid = 2'b00;
      flush     = 1'b1;
      #1;
      chk("t3_busy", 64'(busy), 64'd1);
      tick();
      flush = 1'b0;
      chk("t3_drain_busy", 64'(busy), 64'd1);
      chk("t3_drain_state", 64'(dut.state_q), 64'd2);
      tick();
      fu_done   = 1'b1;
      fu_result = 64'h44;
      #1;
      chk("t3_no_wb_pre", 64'(wb_valid), 64'd0);
      tick();
      fu_done = 1'b0;
      chk("t3_no_wb", 64'(wb_valid), 64'd0);
      chk("t3_idle", 64'(busy), 64'd0);

      // Flush and done in the same BUSY cycle
      req_valid   = 2'b10;
      req_tid[1]  = 3'd6;
      req_data[1] = 64'h66;
      #1;
      chk("t4_grant_p1", 64'(req_ready), 64'b10);
      tick();
      req_valid = 2'b00;
      fu_done   = 1'b1;
      flush     = 1'b1;
      tick();
      fu_done = 1'b0;
      flush   = 1'b0;
      chk("t4_no_wb", 64'(wb_valid), 64'd0);
      chk("t4_idle", 64'(busy), 64'd0);
      req_valid   = 2'b01;
      req_tid[0]  = 3'd4;
      req_data[0] = 64'h70;
      #1;
      chk("t4_regrant", 64'(req_ready), 64'b01);
      chk("t4_regrant_fu_valid", 64'(fu_valid), 64'd1);
      tick();
      req_valid = 2'b00;
      fu_done   = 1'b1;
      fu_result = 64'h77;
      tick();
      fu_done = 1'b0;
      chk("t4_wb_valid", 64'(wb_valid), 64'd1);
      chk("t4_wb_tid", 64'(wb_tid), 64'd4);
      chk("t4_wb_data", wb_data, 64'h77);

      // Flush in IDLE blocks the grant; done in IDLE is ignored
      req_valid = 2'b01;
      flush     = 1'b1;
      #1;
      chk("t5_flush_no_ready", 64'(req_ready), 64'd0);
      chk("t5_flush_no_fu_valid", 64'(fu_valid), 64'd0);
      tick();
      flush     = 1'b0;
      req_valid = 2'b00;
      chk("t5_flush_idle", 64'(busy), 64'd0);
      fu_done   = 1'b1;
      fu_result = 64'hEE;
      tick();
      fu_done = 1'b0;
      chk("t5_done_idle_no_wb", 64'(wb_valid), 64'd0);
      chk("t5_done_idle_busy", 64'(busy), 64'd0);

      // Unit not ready: no grant until it is
      fu_ready  = 1'b0;
      req_valid = 2'b11;
      #1;
      chk("t6_nready_ready", 64'(req_ready), 64'd0);
      chk("t6_nready_fu_valid", 64'(fu_valid), 64'd0);
      chk("t6_nready_fu_data", fu_data, 64'd0);
      tick();
      chk("t6_nready_idle", 64'(busy), 64'd0);
      fu_ready = 1'b1;
`ifdef SHARED_FU_RR_ARB_EN
      exp_port = 2'd1;
`else
      exp_port = 2'd0;
`endif
      #1;
      chk("t6_ready_grant", 64'(req_ready), (exp_port == 2'd0) ? 64'b01 : 64'b10);
      chk("t6_ready_fu_valid", 64'(fu_valid), 64'd1);
      tick();
      req_valid = 2'b00;

      // Reset mid-BUSY, then a late done
      #1;
      chk("t7_busy_before_rst", 64'(busy), 64'd1);
      rst = 1'b1;
      #1;
      chk("t7_rst_busy", 64'(busy), 64'd0);
      chk("t7_rst_wb_valid", 64'(wb_valid), 64'd0);
      chk("t7_rst_wb_tid", 64'(wb_tid), 64'd0);
      chk("t7_rst_wb_data", wb_data, 64'd0);
      chk("t7_rst_fu_valid", 64'(fu_valid), 64'd0);
      rst = 1'b0;
      tick();
      fu_done   = 1'b1;
      fu_result = 64'h55;
      tick();
      fu_done = 1'b0;
      chk("t7_late_done_no_wb", 64'(wb_valid), 64'd0);
      chk("t7_late_done_idle", 64'(busy), 64'd0);
      chk("t7_late_wb_data", wb_data, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/shared_fu_arbiter.md
SHARED_FU_ARBITER -- requirements
Module: shared_fu_arbiter

Interface
REQ-001 Parameter NR_REQ, default 2: number of issue ports requesting the shared unit.
REQ-002 Parameter TRANS_ID_BITS, default 3: scoreboard transaction ID width.
REQ-003 Parameter DATA_W, default 64: operand/result width.
REQ-004 clk_i  in  1  single clock; all state on rising edge.
REQ-005 rst_i  in  1  asynchronous, active-high reset.
REQ-006 flush_i  in  1  kill unissued request and in-flight operation.
REQ-007 req_valid_i  in  NR_REQ  per-port issue request.
REQ-008 req_ready_o  out  NR_REQ  per-port grant; at most one bit set.
REQ-009 req_trans_id_i  in  NR_REQ x TRANS_ID_BITS  per-port transaction ID.
REQ-010 req_data_i  in  NR_REQ x DATA_W  per-port operand.
REQ-011 fu_valid_o  out  1  start pulse to shared unit.
REQ-012 fu_ready_i  in  1  shared unit can accept an operation.
REQ-013 fu_data_o  out  DATA_W  operand of granted port.
REQ-014 fu_done_i  in  1  shared unit result valid, single-cycle pulse.
REQ-015 fu_result_i  in  DATA_W  shared unit result.
REQ-016 wb_valid_o  out  1  writeback to scoreboard.
REQ-017 wb_trans_id_o  out  TRANS_ID_BITS  ID of written-back operation.
REQ-018 wb_data_o  out  DATA_W  written-back result.
REQ-019 busy_o  out  1  state is not IDLE.

Function
REQ-020 States SHALL be IDLE, BUSY, DRAIN; one operation in flight maximum.
REQ-021 In IDLE with fu_ready_i=1 and flush_i=0, req_ready_o SHALL be one-hot on the arbitration winner among req_valid_i, else all zero.
REQ-022 Handshake = req_valid_i[k] & req_ready_o[k]; same cycle fu_valid_o=1, fu_data_o=req_data_i[k] (combinational, zero latency).
REQ-023 On handshake: capture req_trans_id_i[k], IDLE->BUSY.
REQ-024 BUSY and DRAIN: req_ready_o=0, fu_valid_o=0.
REQ-025 BUSY with fu_done_i=1, flush_i=0: register result; wb_valid_o=1 for exactly the next cycle with captured ID and fu_result_i; ->IDLE.
REQ-026 A new grant SHALL be allowed in the same cycle wb_valid_o is high.
REQ-027 flush_i in IDLE: no grant that cycle, stay IDLE.
REQ-028 flush_i in BUSY without fu_done_i: ->DRAIN; with fu_done_i: ->IDLE, no writeback.
REQ-029 DRAIN: wait for fu_done_i, discard result, ->IDLE; flush_i in DRAIN has no further effect.
REQ-030 flush_i SHALL clear a pending wb_valid_o register for the following cycle.
REQ-031 fu_done_i in IDLE SHALL be ignored.
REQ-032 fu_data_o SHALL be zero when fu_valid_o=0.

Reset
REQ-033 rst_i asserted: state IDLE, round-robin pointer 0, wb_valid_o=0, wb_trans_id_o=0, wb_data_o=0, busy_o=0, req_ready_o=0, fu_valid_o=0, immediately and independent of clk_i.
REQ-034 Reset during BUSY SHALL abandon the operation; a later fu_done_i SHALL be ignored.

Configuration
REQ-035 Macro SHARED_FU_RR_ARB_EN defined: round-robin; winner = first valid port at or after pointer; pointer <- winner+1 (mod NR_REQ) on handshake only.
REQ-036 Macro undefined: fixed priority, lowest-index valid port wins, no pointer register.

Structure
REQ-037 State enum (IDLE/BUSY/DRAIN) SHALL live in ariane_pkg as shared_fu_state_e.
REQ-038 Round-robin/priority selection SHALL be one sub-module, shared_fu_rr_sel, producing one-hot grant and index.

Verification
REQ-039 Port 0 valid, ID=5, data=0x11; done 3 cycles later with 0x22 -> one wb pulse, ID 5, data 0x22, cycle after done.
REQ-040 RR build, both ports valid continuously, done 1 cycle after each grant -> grants alternate 0,1,0,1; fixed build -> always 0.
REQ-041 Flush 1 cycle after grant, done 2 cycles later -> DRAIN entered, no wb_valid_o, busy_o low after done.
REQ-042 flush_i and fu_done_i same cycle in BUSY -> no writeback, IDLE next cycle, new grant possible.
REQ-043 fu_ready_i=0 with ports valid -> req_ready_o=0, no fu_valid_o until fu_ready_i=1.
REQ-044 rst_i asserted mid-BUSY, then fu_done_i -> all outputs zero, no writeback.
